freq_sweep_ctrl: RTL and testbench

Parametrised sweep sequencer that generates the phase-increment word for a DDS phase-input stream.
- Steps the word through N+1 frequencies in up, down, triangle or single-shot mode.
- Holds each frequency for a programmable dwell.
- Sits between the TX control registers and the DDS compiler's s_axis_phase port, with a full valid/ready handshake.

---
 rtl/freq_sweep_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// freq_sweep_ctrl
//
// Sweep sequencer that produces phase-increment words for a DDS phase-input
// stream. The word steps through cfg_num_steps+1 frequencies in up-repeat,
// down-repeat, triangle or single-shot mode. Each frequency is presented once
// with a valid/ready handshake and then held for a programmable dwell.
//
// Ports:
//   GCLK           system clock
//   reset          synchronous, active-high reset (priority over MODULE_ENA)
//   MODULE_ENA     run enable; low returns to IDLE and clears all outputs
//   cfg_start      phase increment at index 0
//   cfg_step       increment added/subtracted per step (modulo 2^PINC_W)
//   cfg_num_steps  N, last index of the sweep
//   cfg_dwell      cycles held per frequency (0 behaves as 1)
//   cfg_mode       00 up-repeat, 01 down-repeat, 10 triangle, 11 single-shot
//   pinc_tdata     phase increment to DDS
//   pinc_tvalid    pinc_tdata valid (ISSUE state)
//   pinc_tready    DDS accepts the word
//   step_idx       current index
//   step_strobe    one-cycle pulse on the first ISSUE cycle of each word
//   busy           high in ISSUE and DWELL
//   sweep_done     high in DONE (single-shot only)
// -----------------------------------------------------------------------------
module freq_sweep_ctrl #(
    parameter int unsigned PINC_W  = 24,
    parameter int unsigned STEPS_W = 8,
    parameter int unsigned DWELL_W = 32
) (
    input  logic               GCLK,
    input  logic               reset,
    input  logic               MODULE_ENA,
    input  logic [PINC_W-1:0]  cfg_start,
    input  logic [PINC_W-1:0]  cfg_step,
    input  logic [STEPS_W-1:0] cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [PINC_W-1:0]  pinc_tdata,
    output logic               pinc_tvalid,
    input  logic               pinc_tready,
    output logic [STEPS_W-1:0] step_idx,
    output logic               step_strobe,
    output logic               busy,
    output logic               sweep_done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDwell = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [1:0] ModeUp     = 2'b00;
    localparam logic [1:0] ModeDown   = 2'b01;
    localparam logic [1:0] ModeTri    = 2'b10;
    localparam logic [1:0] ModeSingle = 2'b11;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [PINC_W-1:0]  pinc_q, pinc_d;
    logic [STEPS_W-1:0] idx_q, idx_d;
    logic               strobe_q, strobe_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               dir_up_q, dir_up_d;

    // Shadow copies of the configuration, captured when leaving IDLE.
    logic [PINC_W-1:0]  start_q;
    logic [PINC_W-1:0]  step_q;
    logic [STEPS_W-1:0] num_q;
    logic [DWELL_W-1:0] dwell_last_q;
    logic [1:0]         mode_q;
    logic               load_cfg;
    logic [DWELL_W-1:0] dwell_last_in;

    // Next-word computation
    logic [STEPS_W-1:0] nxt_idx;
    logic [PINC_W-1:0]  nxt_pinc;
    logic               nxt_dir_up;
    logic               last_word;
    logic               at_end;
    logic               dwell_end;

    // Dwell of 0 is treated as 1, so the terminal count is max(dwell,1)-1.
    assign dwell_last_in = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
    assign load_cfg      = (state_q == StIdle) && MODULE_ENA;

    assign at_end    = (idx_q == num_q);
    assign dwell_end = (cnt_q == dwell_last_q);

    // ------------------------------------------------------------------------
    // Next index / phase increment from the current word
    // ------------------------------------------------------------------------
    always_comb begin
        nxt_idx    = idx_q;
        nxt_pinc   = pinc_q;
        nxt_dir_up = dir_up_q;
        last_word  = 1'b0;

        unique case (mode_q)
            ModeUp, ModeSingle: begin
                if (at_end) begin
                    // Reload rather than accumulate so the sweep never drifts.
                    nxt_idx   = '0;
                    nxt_pinc  = start_q;
                    last_word = (mode_q == ModeSingle);
                end else begin
                    nxt_idx  = idx_q + 1'b1;
                    nxt_pinc = pinc_q + step_q;
                end
            end
            ModeDown: begin
                if (at_end) begin
                    nxt_idx  = '0;
                    nxt_pinc = start_q;
                end else begin
                    nxt_idx  = idx_q + 1'b1;
                    nxt_pinc = pinc_q - step_q;
                end
            end
            ModeTri: begin
                if (num_q == '0) begin
                    // Single-point triangle: keep reissuing the start word.
                    nxt_idx  = '0;
                    nxt_pinc = start_q;
                end else if (dir_up_q) begin
                    if (at_end) begin
                        nxt_dir_up = 1'b0;
                        nxt_idx    = idx_q - 1'b1;
                        nxt_pinc   = pinc_q - step_q;
                    end else begin
                        nxt_idx  = idx_q + 1'b1;
                        nxt_pinc = pinc_q + step_q;
                    end
                end else begin
                    if (idx_q == '0) begin
                        nxt_dir_up = 1'b1;
                        nxt_idx    = idx_q + 1'b1;
                        nxt_pinc   = pinc_q + step_q;
                    end else begin
                        nxt_idx  = idx_q - 1'b1;
                        nxt_pinc = pinc_q - step_q;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pinc_d   = pinc_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;

        unique case (state_q)
            StIdle: begin
                if (MODULE_ENA) begin
                    state_d  = StIssue;
                    pinc_d   = cfg_start;
                    idx_d    = '0;
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                    dir_up_d = 1'b1;
                end
            end
            StIssue: begin
                // Word and counter are frozen until the DDS takes the word.
                if (pinc_tready) begin
                    state_d = StDwell;
                    cnt_d   = '0;
                end
            end
            StDwell: begin
                if (dwell_end) begin
                    if (last_word) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StIssue;
                        pinc_d   = nxt_pinc;
                        idx_d    = nxt_idx;
                        dir_up_d = nxt_dir_up;
                        strobe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
        endcase

        // Dropping the enable abandons any word in flight.
        if (!MODULE_ENA) begin
            state_d  = StIdle;
            pinc_d   = '0;
            idx_d    = '0;
            strobe_d = 1'b0;
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end
    end

    always_ff @(posedge GCLK) begin
        if (reset) begin
            state_q  <= StIdle;
            pinc_q   <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pinc_q   <= pinc_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
        end
    end

    always_ff @(posedge GCLK) begin
        if (reset) begin
            start_q      <= '0;
            step_q       <= '0;
            num_q        <= '0;
            dwell_last_q <= '0;
            mode_q       <= ModeUp;
        end else if (load_cfg) begin
            start_q      <= cfg_start;
            step_q       <= cfg_step;
            num_q        <= cfg_num_steps;
            dwell_last_q <= dwell_last_in;
            mode_q       <= cfg_mode;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pinc_tdata  = pinc_q;
    assign pinc_tvalid = (state_q == StIssue);
    assign step_idx    = idx_q;
    assign step_strobe = strobe_q;
    assign busy        = (state_q == StIssue) || (state_q == StDwell);
    assign sweep_done  = (state_q == StDone);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_sweep_ctrl
//
// Directed bench for freq_sweep_ctrl: reset state, up/down/triangle/single-shot
// sequences, wrap-around, stalled handshake, reset mid-dwell, dwell=0 and N=0.
// -----------------------------------------------------------------------------
module tb_freq_sweep_ctrl;

    logic        GCLK = 1'b0;
    logic        reset;
    logic        MODULE_ENA;
    logic [23:0] cfg_start;
    logic [23:0] cfg_step;
    logic [7:0]  cfg_num_steps;
    logic [31:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [23:0] pinc_tdata;
    logic        pinc_tvalid;
    logic        pinc_tready;
    logic [7:0]  step_idx;
    logic        step_strobe;
    logic        busy;
    logic        sweep_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_cyc    = 0;

    freq_sweep_ctrl #(
        .PINC_W (24),
        .STEPS_W(8),
        .DWELL_W(32)
    ) dut (
        .GCLK         (GCLK),
        .reset        (reset),
        .MODULE_ENA   (MODULE_ENA),
        .cfg_start    (cfg_start),
        .cfg_step     (cfg_step),
        .cfg_num_steps(cfg_num_steps),
        .cfg_dwell    (cfg_dwell),
        .cfg_mode     (cfg_mode),
        .pinc_tdata   (pinc_tdata),
        .pinc_tvalid  (pinc_tvalid),
        .pinc_tready  (pinc_tready),
        .step_idx     (step_idx),
        .step_strobe  (step_strobe),
        .busy         (busy),
        .sweep_done   (sweep_done)
    );

    always #5 GCLK = ~GCLK;
    always @(posedge GCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Wait (bounded) for the next step_strobe and check the presented word.
    task automatic wait_word(input string tag, input logic [23:0] exp_pinc,
                             input logic [7:0] exp_idx, input int exp_gap);
        int n = 0;
        do begin
            @(negedge GCLK);
            n++;
        end while (!step_strobe && n < 100);
        check_eq({tag, ".strobe"}, {31'd0, step_strobe}, 32'd1);
        check_eq({tag, ".pinc"}, {8'd0, pinc_tdata}, {8'd0, exp_pinc});
        check_eq({tag, ".idx"}, {24'd0, step_idx}, {24'd0, exp_idx});
        check_eq({tag, ".tvalid"}, {31'd0, pinc_tvalid}, 32'd1);
        check_eq({tag, ".busy"}, {31'd0, busy}, 32'd1);
        if (exp_gap != 0) check_eq({tag, ".gap"}, cyc - last_cyc, exp_gap);
        last_cyc = cyc;
    endtask

    // Drop the enable for one cycle, load a new configuration and re-enable.
    task automatic restart(input logic [1:0] mode, input logic [23:0] start,
                           input logic [23:0] step, input logic [7:0] n,
                           input logic [31:0] dwell);
        @(negedge GCLK);
        MODULE_ENA = 1'b0;
        @(negedge GCLK);
        check_eq("idle.busy", {31'd0, busy}, 32'd0);
        check_eq("idle.tvalid", {31'd0, pinc_tvalid}, 32'd0);
        check_eq("idle.done", {31'd0, sweep_done}, 32'd0);
        check_eq("idle.pinc", {8'd0, pinc_tdata}, 32'd0);
        cfg_mode      = mode;
        cfg_start     = start;
        cfg_step      = step;
        cfg_num_steps = n;
        cfg_dwell     = dwell;
        MODULE_ENA    = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".pinc"}, {8'd0, pinc_tdata}, 32'd0);
        check_eq({tag, ".tvalid"}, {31'd0, pinc_tvalid}, 32'd0);
        check_eq({tag, ".idx"}, {24'd0, step_idx}, 32'd0);
        check_eq({tag, ".strobe"}, {31'd0, step_strobe}, 32'd0);
        check_eq({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, ".done"}, {31'd0, sweep_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] up_p  [5] = '{24'h000800, 24'h001000, 24'h001800, 24'h002000, 24'h000800};
        logic [7:0]  up_i  [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        logic [23:0] tri_p [7] = '{24'h100, 24'h200, 24'h300, 24'h200, 24'h100, 24'h200, 24'h300};
        logic [7:0]  tri_i [7] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
        logic [23:0] dn_p  [3] = '{24'h000010, 24'hFFFFF0, 24'h000010};
        logic [23:0] d0_p  [3] = '{24'h000500, 24'h000600, 24'h000500};

        reset         = 1'b1;
        MODULE_ENA    = 1'b0;
        pinc_tready   = 1'b1;
        cfg_mode      = 2'b00;
        cfg_start     = 24'h000800;
        cfg_step      = 24'h000800;
        cfg_num_steps = 8'd3;
        cfg_dwell     = 32'd4;
        repeat (3) @(negedge GCLK);
        check_zero("reset");

        // Up-repeat, 5 cycles per word.
        reset      = 1'b0;
        MODULE_ENA = 1'b1;
        for (int i = 0; i < 5; i++) wait_word("up", up_p[i], up_i[i], (i == 0) ? 0 : 5);

        // Triangle, N=2, dwell=1.
        restart(2'b10, 24'h100, 24'h100, 8'd2, 32'd1);
        for (int i = 0; i < 7; i++) wait_word("tri", tri_p[i], tri_i[i], (i == 0) ? 0 : 2);

        // Down-repeat wrap-around below zero.
        restart(2'b01, 24'h000010, 24'h000020, 8'd1, 32'd2);
        for (int i = 0; i < 3; i++) wait_word("down", dn_p[i], 8'(i % 2), (i == 0) ? 0 : 3);

        // Single-shot, N=2, dwell=3; config changes mid-run are ignored.
        restart(2'b11, 24'h001000, 24'h000100, 8'd2, 32'd3);
        wait_word("ss", 24'h001000, 8'd0, 0);
        cfg_step  = 24'h007777;
        cfg_start = 24'h00ABCD;
        wait_word("ss", 24'h001100, 8'd1, 4);
        wait_word("ss", 24'h001200, 8'd2, 4);
        repeat (3) @(negedge GCLK);
        check_eq("ss.pre_done", {31'd0, sweep_done}, 32'd0);
        check_eq("ss.pre_busy", {31'd0, busy}, 32'd1);
        @(negedge GCLK);
        check_eq("ss.done", {31'd0, sweep_done}, 32'd1);
        check_eq("ss.busy", {31'd0, busy}, 32'd0);
        check_eq("ss.tvalid", {31'd0, pinc_tvalid}, 32'd0);
        check_eq("ss.pinc", {8'd0, pinc_tdata}, 32'h001200);
        check_eq("ss.idx", {24'd0, step_idx}, 32'd2);
        repeat (4) @(negedge GCLK);
        check_eq("ss.done_hold", {31'd0, sweep_done}, 32'd1);
        check_eq("ss.strobe_hold", {31'd0, step_strobe}, 32'd0);
        restart(2'b11, 24'h003000, 24'h000100, 8'd2, 32'd3);
        wait_word("ss.restart", 24'h003000, 8'd0, 0);

        // Stalled handshake: word held, no strobe repeat, full dwell after accept.
        pinc_tready = 1'b0;
        restart(2'b00, 24'h000040, 24'h000040, 8'd3, 32'd3);
        wait_word("stall", 24'h000040, 8'd0, 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge GCLK);
            check_eq("stall.pinc", {8'd0, pinc_tdata}, 32'h40);
            check_eq("stall.tvalid", {31'd0, pinc_tvalid}, 32'd1);
            check_eq("stall.strobe", {31'd0, step_strobe}, 32'd0);
        end
        pinc_tready = 1'b1;
        last_cyc    = cyc;
        wait_word("stall", 24'h000080, 8'd1, 4);
        wait_word("stall", 24'h0000C0, 8'd2, 4);

        // Reset mid-DWELL at idx=2 with MODULE_ENA still high.
        @(negedge GCLK);
        check_eq("rst.in_dwell", {31'd0, pinc_tvalid}, 32'd0);
        reset = 1'b1;
        @(negedge GCLK);
        check_zero("rst");
        reset = 1'b0;
        wait_word("rst.resume", 24'h000040, 8'd0, 0);

        // Dwell=0 behaves as dwell=1.
        restart(2'b00, 24'h000500, 24'h000100, 8'd1, 32'd0);
        for (int i = 0; i < 3; i++) wait_word("d0", d0_p[i], 8'(i % 2), (i == 0) ? 0 : 2);

        // N=0 in triangle mode reissues the start word.
        restart(2'b10, 24'h000900, 24'h000100, 8'd0, 32'd1);
        for (int i = 0; i < 3; i++) wait_word("n0", 24'h000900, 8'd0, (i == 0) ? 0 : 2);

        // Enable drop with an unaccepted word abandons it.
        pinc_tready = 1'b0;
        restart(2'b00, 24'h000700, 24'h000100, 8'd3, 32'd2);
        wait_word("abandon", 24'h000700, 8'd0, 0);
        MODULE_ENA = 1'b0;
        @(negedge GCLK);
        check_zero("abandon");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
